// File: rtl/instr_fetch_mem_pkg.sv
// Shared types and constants for the instruction fetch memory.
// Holds the fetch FSM states, word/byte widths and the bad-address rule.
package instr_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] BAD_FETCH_WORD = 32'h0000_0000;

  // Misaligned, or the last byte of the word falls outside the array.
  function automatic logic is_bad_addr(input logic [WORD_W-1:0] addr,
                                       input int unsigned       depth);
    logic [WORD_W:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return (addr[1:0] != 2'b00) || (last_byte >= 33'(depth));
  endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch and program-load signal bundle between the CPU side and the memory.
// The master modport is the CPU / loader, the slave modport is the memory.
interface instr_fetch_mem_if
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) ();

  logic [WORD_W-1:0] PC;
  logic              READ;
  logic [WORD_W-1:0] INSTRUCTION;
  logic              BUSYWAIT;
  logic              ERR;
  logic              PROG_WE;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [BYTE_W-1:0] PROG_DATA;

  modport master (
    output PC, READ, PROG_WE, PROG_ADDR, PROG_DATA,
    input  INSTRUCTION, BUSYWAIT, ERR
  );

  modport slave (
    input  PC, READ, PROG_WE, PROG_ADDR, PROG_DATA,
    output INSTRUCTION, BUSYWAIT, ERR
  );

endinterface

// File: rtl/instr_fetch_mem_array.sv
// Byte-wide instruction storage: one byte write port, one 4-byte little-endian
// combinational read port with write-first bypass of a same-edge write.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_byte
    logic [ADDR_W-1:0] w_idx;
    assign w_idx = i_rd_addr + ADDR_W'(k);
    assign o_rd_data[k*BYTE_W +: BYTE_W] =
      (i_we && (i_wr_addr == w_idx)) ? i_wr_data : r_mem[w_idx];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: fixed-latency word fetch with BUSYWAIT stall,
// repeat-request suppression and byte program-load. Optional next-word
// prefetch is enabled by defining INSTR_PREFETCH_EN.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES  = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 4
) (
  input logic              CLK,
  input logic              RESET,
  instr_fetch_mem_if.slave bus
);

  localparam int              CNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  fetch_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0] r_addr, w_addr_nxt;
  logic [WORD_W-1:0] r_last_pc, w_last_pc_nxt;
  logic              r_last_valid, w_last_valid_nxt;
  logic [WORD_W-1:0] r_instr, w_instr_nxt;
  logic              r_err, w_err_nxt;
  logic              w_busy;
  logic [WORD_W-1:0] w_rd_pc, w_rd_data;
  logic              w_rd_bad, w_repeat, w_new_req, w_prog_hit_last;
  logic [WORD_W-1:0] w_prog_addr32;

  assign w_prog_addr32   = WORD_W'(bus.PROG_ADDR);
  assign w_repeat        = r_last_valid && (bus.PC == r_last_pc);
  assign w_new_req       = bus.READ && !w_repeat;
  // Unsigned difference below 4 means the write lands inside the last word.
  assign w_prog_hit_last = bus.PROG_WE && ((w_prog_addr32 - r_last_pc) < 32'd4);
  assign w_rd_bad        = is_bad_addr(w_rd_pc, DEPTH_BYTES);

  instr_mem_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .i_clk     (CLK),
    .i_we      (bus.PROG_WE),
    .i_wr_addr (bus.PROG_ADDR),
    .i_wr_data (bus.PROG_DATA),
    .i_rd_addr (w_rd_pc[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

`ifdef INSTR_PREFETCH_EN
  logic              r_pf_busy, w_pf_busy_nxt;
  logic              r_pf_valid, w_pf_valid_nxt;
  logic              r_pf_err, w_pf_err_nxt;
  logic [CNT_W-1:0]  r_pf_cnt, w_pf_cnt_nxt;
  logic [WORD_W-1:0] r_pf_addr, w_pf_addr_nxt;
  logic [WORD_W-1:0] r_pf_buf, w_pf_buf_nxt;
  logic              w_pf_hit, w_pf_wait, w_pf_done, w_prog_hit_pf;

  // The read port serves the prefetcher whenever no demand fetch is running.
  assign w_rd_pc       = (r_state == FETCH) ? r_addr : r_pf_addr;
  assign w_pf_hit      = r_pf_valid && (bus.PC == r_pf_addr);
  assign w_pf_wait     = r_pf_busy && (bus.PC == r_pf_addr);
  assign w_pf_done     = r_pf_busy && (r_pf_cnt == '0);
  assign w_prog_hit_pf = bus.PROG_WE && ((w_prog_addr32 - r_pf_addr) < 32'd4);
`else
  assign w_rd_pc = r_addr;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_instr_nxt      = r_instr;
    w_err_nxt        = r_err;
    w_last_pc_nxt    = r_last_pc;
    w_last_valid_nxt = r_last_valid && !w_prog_hit_last;
    w_busy           = 1'b0;
`ifdef INSTR_PREFETCH_EN
    w_pf_busy_nxt    = r_pf_busy;
    w_pf_valid_nxt   = r_pf_valid && !w_prog_hit_pf;
    w_pf_err_nxt     = r_pf_err;
    w_pf_cnt_nxt     = r_pf_cnt;
    w_pf_addr_nxt    = r_pf_addr;
    w_pf_buf_nxt     = r_pf_buf;
`endif
    case (r_state)
      IDLE: begin
`ifdef INSTR_PREFETCH_EN
        if (w_new_req && w_pf_hit) begin
          w_instr_nxt      = r_pf_buf;
          w_err_nxt        = r_pf_err;
          w_last_pc_nxt    = r_pf_addr;
          w_last_valid_nxt = 1'b1;
          w_pf_addr_nxt    = r_pf_addr + 32'd4;
          w_pf_busy_nxt    = 1'b1;
          w_pf_valid_nxt   = 1'b0;
          w_pf_cnt_nxt     = CNT_LOAD;
        end else if (w_new_req && !w_pf_wait) begin
          w_busy         = 1'b1;
          w_addr_nxt     = bus.PC;
          w_cnt_nxt      = CNT_LOAD;
          w_state_nxt    = FETCH;
          w_pf_busy_nxt  = 1'b0;
          w_pf_valid_nxt = 1'b0;
        end else if (r_pf_busy) begin
          // A request for the in-flight address just waits for the prefetch.
          w_busy = w_new_req;
          if (w_pf_done) begin
            w_pf_busy_nxt = 1'b0;
            if (w_new_req) begin
              w_instr_nxt      = w_rd_bad ? BAD_FETCH_WORD : w_rd_data;
              w_err_nxt        = w_rd_bad;
              w_last_pc_nxt    = r_pf_addr;
              w_last_valid_nxt = 1'b1;
              w_pf_addr_nxt    = r_pf_addr + 32'd4;
              w_pf_busy_nxt    = 1'b1;
              w_pf_valid_nxt   = 1'b0;
              w_pf_cnt_nxt     = CNT_LOAD;
            end else begin
              w_pf_buf_nxt   = w_rd_bad ? BAD_FETCH_WORD : w_rd_data;
              w_pf_err_nxt   = w_rd_bad;
              w_pf_valid_nxt = 1'b1;
            end
          end else begin
            w_pf_cnt_nxt = r_pf_cnt - 1'b1;
          end
        end
`else
        if (w_new_req) begin
          w_busy      = 1'b1;
          w_addr_nxt  = bus.PC;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = FETCH;
        end
`endif
      end
      FETCH: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_instr_nxt      = w_rd_bad ? BAD_FETCH_WORD : w_rd_data;
          w_err_nxt        = w_rd_bad;
          w_last_pc_nxt    = r_addr;
          w_last_valid_nxt = 1'b1;
          w_state_nxt      = IDLE;
`ifdef INSTR_PREFETCH_EN
          w_pf_addr_nxt    = r_addr + 32'd4;
          w_pf_busy_nxt    = 1'b1;
          w_pf_valid_nxt   = 1'b0;
          w_pf_cnt_nxt     = CNT_LOAD;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state: reset aborts any access and clears the output word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_instr      <= '0;
      r_err        <= 1'b0;
      r_last_valid <= 1'b0;
`ifdef INSTR_PREFETCH_EN
      r_pf_busy    <= 1'b0;
      r_pf_valid   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_instr      <= w_instr_nxt;
      r_err        <= w_err_nxt;
      r_last_valid <= w_last_valid_nxt;
`ifdef INSTR_PREFETCH_EN
      r_pf_busy    <= w_pf_busy_nxt;
      r_pf_valid   <= w_pf_valid_nxt;
`endif
    end
  end

  // Address/count payload is only meaningful under the control state above.
  always_ff @(posedge CLK) begin
    r_cnt     <= w_cnt_nxt;
    r_addr    <= w_addr_nxt;
    r_last_pc <= w_last_pc_nxt;
`ifdef INSTR_PREFETCH_EN
    r_pf_cnt  <= w_pf_cnt_nxt;
    r_pf_addr <= w_pf_addr_nxt;
    r_pf_buf  <= w_pf_buf_nxt;
    r_pf_err  <= w_pf_err_nxt;
`endif
  end

  assign bus.BUSYWAIT    = w_busy && !RESET;
  assign bus.INSTRUCTION = r_instr;
  assign bus.ERR         = r_err;

endmodule
